// File: rtl/clk_gate_sched.sv
// clk_gate_sched: drives GATE enables of per-bank clock-gate cells.
// Demand-driven wake, idle hysteresis, power-budget cap with preemption.
module clk_gate_sched #(
  parameter int NUM_BANKS   = 4,
  parameter int MAX_ON      = 2,
  parameter int WAKE_CYCLES = 1,
  parameter int IDLE_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_BANKS-1:0]           req,
  input  logic                           force_on,
  output logic [NUM_BANKS-1:0]           gate_en,
  output logic [NUM_BANKS-1:0]           ready,
  output logic [$clog2(NUM_BANKS+1)-1:0] on_count
);

  localparam int OCW = $clog2(NUM_BANKS + 1);
  localparam int PW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  localparam logic [OCW-1:0]   MAX_C   = OCW'(MAX_ON);
  localparam logic [OCW-1:0]   ALL_C   = OCW'(NUM_BANKS);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_OFF,
    S_WAKE,
    S_ON,
    S_LINGER
  } st_e;

  st_e              st_q  [NUM_BANKS];
  st_e              st_d  [NUM_BANKS];
  logic [CNT_W-1:0] cnt_q [NUM_BANKS];
  logic [CNT_W-1:0] cnt_d [NUM_BANKS];

  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 force_q;
  logic [NUM_BANKS-1:0] gate_q, gate_d;
  logic [NUM_BANKS-1:0] rdy_q, rdy_d;
  logic [OCW-1:0]       oc_q, oc_d;

  logic [OCW-1:0]       busy;
  logic [NUM_BANKS-1:0] off_req;
  logic [NUM_BANKS-1:0] lin_idle;
  logic                 can_gnt;
  logic                 gnt_ok;
  logic [PW-1:0]        gnt_idx;
  logic [PW-1:0]        ptr_nxt;
  logic                 pre_ok;
  logic [PW-1:0]        pre_idx;
  logic                 preempt;
  int                   idx;

  always_comb begin
    busy     = '0;
    off_req  = '0;
    lin_idle = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (st_q[i] != S_OFF) busy = busy + OCW'(1);
      off_req[i]  = (st_q[i] == S_OFF) && req[i];
      lin_idle[i] = (st_q[i] == S_LINGER) && !req[i];
    end
  end

  // Round-robin search over OFF requesters, starting at the pointer.
  always_comb begin
    can_gnt = busy < MAX_C;
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      idx = (int'(ptr_q) + k) % NUM_BANKS;
      if (can_gnt && !gnt_ok && off_req[PW'(idx)]) begin
        gnt_ok  = 1'b1;
        gnt_idx = PW'(idx);
      end
    end
    ptr_nxt = (int'(gnt_idx) == NUM_BANKS - 1) ? '0
            : gnt_idx + PW'(1);
  end

  // A lingering bank whose req is back is about to reopen; never evict it.
  always_comb begin
    pre_ok  = 1'b0;
    pre_idx = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (lin_idle[i]) begin
        pre_ok  = 1'b1;
        pre_idx = PW'(i);
      end
    end
    preempt = (busy == MAX_C) && (|off_req) && pre_ok;
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    if (!force_on && force_q) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        st_d[i]  = S_OFF;
        cnt_d[i] = '0;
      end
    end else if (!force_on) begin
      if (gnt_ok) ptr_d = ptr_nxt;
      for (int i = 0; i < NUM_BANKS; i++) begin
        unique case (st_q[i])
          S_OFF: begin
            if (gnt_ok && int'(gnt_idx) == i) begin
              st_d[i]  = S_WAKE;
              cnt_d[i] = WAKE_LD;
            end
          end
          S_WAKE: begin
            if (cnt_q[i] <= CNT_ONE) st_d[i] = S_ON;
            else cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
          S_ON: begin
            if (!req[i]) begin
              st_d[i]  = S_LINGER;
              cnt_d[i] = IDLE_LD;
            end
          end
          S_LINGER: begin
            if (req[i]) begin
              st_d[i] = S_ON;
            end else if (preempt && int'(pre_idx) == i) begin
              st_d[i] = S_OFF;
            end else if (cnt_q[i] <= CNT_ONE) begin
              st_d[i] = S_OFF;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
          end
          default: st_d[i] = S_OFF;
        endcase
      end
    end
  end

  always_comb begin
    gate_d = '0;
    rdy_d  = '0;
    oc_d   = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      gate_d[i] = st_d[i] != S_OFF;
      rdy_d[i]  = (st_d[i] == S_ON) || (st_d[i] == S_LINGER);
      if (gate_d[i]) oc_d = oc_d + OCW'(1);
    end
    if (force_on) begin
      gate_d = '1;
      rdy_d  = '1;
      oc_d   = ALL_C;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        st_q[i]  <= S_OFF;
        cnt_q[i] <= '0;
      end
      ptr_q   <= '0;
      force_q <= 1'b0;
      gate_q  <= '0;
      rdy_q   <= '0;
      oc_q    <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      force_q <= force_on;
      gate_q  <= gate_d;
      rdy_q   <= rdy_d;
      oc_q    <= oc_d;
    end
  end

  assign gate_en  = gate_q;
  assign ready    = rdy_q;
  assign on_count = oc_q;

endmodule

// File: tb/tb_clk_gate_sched.sv
// tb_clk_gate_sched: scoreboard bench for clk_gate_sched.
// Each row drives one cycle and queues the outputs expected after its edge.
module tb_clk_gate_sched;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       force_on;
  logic [3:0] gate_en;
  logic [3:0] ready;
  logic [2:0] on_count;

  int checks;
  int errors;
  bit mon_en;
  bit force_d1;

  typedef struct {
    logic       r;
    logic [3:0] q;
    logic       f;
    logic [3:0] g;
    logic [3:0] y;
    logic [2:0] c;
  } row_t;

  typedef struct {
    logic [3:0] g;
    logic [3:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t sb[$];

  clk_gate_sched #(
    .NUM_BANKS  (4),
    .MAX_ON     (2),
    .WAKE_CYCLES(1),
    .IDLE_CYCLES(8),
    .CNT_W      (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .force_on(force_on),
    .gate_en (gate_en),
    .ready   (ready),
    .on_count(on_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) force_d1 <= force_on;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      checks++;
      if ((ready & ~gate_en) != 4'b0000) begin
        errors++;
        $display("FAIL inv_ready ready=%b gate_en=%b", ready, gate_en);
      end
      if (!force_d1) begin
        checks++;
        if ($countones(gate_en) > 2) begin
          errors++;
          $display("FAIL inv_budget gate_en=%b popcount=%0d max 2",
                   gate_en, $countones(gate_en));
        end
      end
    end
  end

  function automatic row_t mk(input logic r, input logic [3:0] q,
                              input logic f, input logic [3:0] g,
                              input logic [3:0] y, input logic [2:0] c);
    row_t t;
    t.r = r; t.q = q; t.f = f;
    t.g = g; t.y = y; t.c = c;
    return t;
  endfunction

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 4'b1111, 1, 4'b0000, 4'b0000, 3'd0));
    rows.push_back(mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 3'd0));
    rows.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 3'd0));
    rows.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 3'd0));
    foreach (rows[k]) begin
      rst = rows[k].r; req = rows[k].q; force_on = rows[k].f;
      sb.push_back('{rows[k].g, rows[k].y, rows[k].c});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (gate_en !== e.g || ready !== e.y || on_count !== e.c) begin
        errors++;
        $display("FAIL reset row %0d: got %b %b %0d, want %b %b %0d",
                 k, gate_en, ready, on_count, e.g, e.y, e.c);
      end
    end
  endtask

  task automatic test_hysteresis();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 3'd0));
    rows.push_back(mk(0, 4'b0001, 0, 4'b0001, 4'b0000, 3'd1));
    rows.push_back(mk(0, 4'b0001, 0, 4'b0001, 4'b0001, 3'd1));
    rows.push_back(mk(0, 4'b0001, 0, 4'b0001, 4'b0001, 3'd1));
    for (int i = 0; i < 8; i++)
      rows.push_back(mk(0, 4'b0000, 0, 4'b0001, 4'b0001, 3'd1));
    rows.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 3'd0));
    rows.push_back(mk(0, 4'b0001, 0, 4'b0001, 4'b0000, 3'd1));
    rows.push_back(mk(0, 4'b0001, 0, 4'b0001, 4'b0001, 3'd1));
    for (int i = 0; i < 4; i++)
      rows.push_back(mk(0, 4'b0000, 0, 4'b0001, 4'b0001, 3'd1));
    for (int i = 0; i < 3; i++)
      rows.push_back(mk(0, 4'b0001, 0, 4'b0001, 4'b0001, 3'd1));
    for (int i = 0; i < 8; i++)
      rows.push_back(mk(0, 4'b0000, 0, 4'b0001, 4'b0001, 3'd1));
    rows.push_back(mk(0, 4'b0000, 0, 4'b0000, 4'b0000, 3'd0));
    foreach (rows[k]) begin
      rst = rows[k].r; req = rows[k].q; force_on = rows[k].f;
      sb.push_back('{rows[k].g, rows[k].y, rows[k].c});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (gate_en !== e.g || ready !== e.y || on_count !== e.c) begin
        errors++;
        $display("FAIL hysteresis row %0d: got %b %b %0d, want %b %b %0d",
                 k, gate_en, ready, on_count, e.g, e.y, e.c);
      end
    end
  endtask

  task automatic test_round_robin();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 3'd0));
    rows.push_back(mk(0, 4'b1111, 0, 4'b0001, 4'b0000, 3'd1));
    rows.push_back(mk(0, 4'b1111, 0, 4'b0011, 4'b0001, 3'd2));
    rows.push_back(mk(0, 4'b1111, 0, 4'b0011, 4'b0011, 3'd2));
    rows.push_back(mk(0, 4'b1111, 0, 4'b0011, 4'b0011, 3'd2));
    rows.push_back(mk(0, 4'b1110, 0, 4'b0011, 4'b0011, 3'd2));
    rows.push_back(mk(0, 4'b1110, 0, 4'b0010, 4'b0010, 3'd1));
    rows.push_back(mk(0, 4'b1110, 0, 4'b0110, 4'b0010, 3'd2));
    rows.push_back(mk(0, 4'b1110, 0, 4'b0110, 4'b0110, 3'd2));
    rows.push_back(mk(0, 4'b1010, 0, 4'b0110, 4'b0110, 3'd2));
    rows.push_back(mk(0, 4'b1010, 0, 4'b0010, 4'b0010, 3'd1));
    rows.push_back(mk(0, 4'b1010, 0, 4'b1010, 4'b0010, 3'd2));
    rows.push_back(mk(0, 4'b1010, 0, 4'b1010, 4'b1010, 3'd2));
    foreach (rows[k]) begin
      rst = rows[k].r; req = rows[k].q; force_on = rows[k].f;
      sb.push_back('{rows[k].g, rows[k].y, rows[k].c});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (gate_en !== e.g || ready !== e.y || on_count !== e.c) begin
        errors++;
        $display("FAIL round_robin row %0d: got %b %b %0d, want %b %b %0d",
                 k, gate_en, ready, on_count, e.g, e.y, e.c);
      end
    end
  endtask

  task automatic test_preempt();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 3'd0));
    rows.push_back(mk(0, 4'b0011, 0, 4'b0001, 4'b0000, 3'd1));
    rows.push_back(mk(0, 4'b0011, 0, 4'b0011, 4'b0001, 3'd2));
    rows.push_back(mk(0, 4'b0011, 0, 4'b0011, 4'b0011, 3'd2));
    rows.push_back(mk(0, 4'b0000, 0, 4'b0011, 4'b0011, 3'd2));
    rows.push_back(mk(0, 4'b1000, 0, 4'b0010, 4'b0010, 3'd1));
    rows.push_back(mk(0, 4'b1000, 0, 4'b1010, 4'b0010, 3'd2));
    rows.push_back(mk(0, 4'b1000, 0, 4'b1010, 4'b1010, 3'd2));
    foreach (rows[k]) begin
      rst = rows[k].r; req = rows[k].q; force_on = rows[k].f;
      sb.push_back('{rows[k].g, rows[k].y, rows[k].c});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (gate_en !== e.g || ready !== e.y || on_count !== e.c) begin
        errors++;
        $display("FAIL preempt row %0d: got %b %b %0d, want %b %b %0d",
                 k, gate_en, ready, on_count, e.g, e.y, e.c);
      end
    end
  endtask

  task automatic test_boundary();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 3'd0));
    rows.push_back(mk(0, 4'b0011, 0, 4'b0001, 4'b0000, 3'd1));
    rows.push_back(mk(0, 4'b0011, 0, 4'b0011, 4'b0001, 3'd2));
    rows.push_back(mk(0, 4'b0011, 0, 4'b0011, 4'b0011, 3'd2));
    rows.push_back(mk(0, 4'b0010, 0, 4'b0011, 4'b0011, 3'd2));
    rows.push_back(mk(0, 4'b1011, 0, 4'b0011, 4'b0011, 3'd2));
    rows.push_back(mk(0, 4'b1011, 0, 4'b0011, 4'b0011, 3'd2));
    rows.push_back(mk(0, 4'b0010, 0, 4'b0011, 4'b0011, 3'd2));
    for (int i = 0; i < 7; i++)
      rows.push_back(mk(0, 4'b0010, 0, 4'b0011, 4'b0011, 3'd2));
    rows.push_back(mk(0, 4'b1010, 0, 4'b0010, 4'b0010, 3'd1));
    rows.push_back(mk(0, 4'b1010, 0, 4'b1010, 4'b0010, 3'd2));
    rows.push_back(mk(0, 4'b1010, 0, 4'b1010, 4'b1010, 3'd2));
    foreach (rows[k]) begin
      rst = rows[k].r; req = rows[k].q; force_on = rows[k].f;
      sb.push_back('{rows[k].g, rows[k].y, rows[k].c});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (gate_en !== e.g || ready !== e.y || on_count !== e.c) begin
        errors++;
        $display("FAIL boundary row %0d: got %b %b %0d, want %b %b %0d",
                 k, gate_en, ready, on_count, e.g, e.y, e.c);
      end
    end
  endtask

  task automatic test_force();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 3'd0));
    rows.push_back(mk(0, 4'b0001, 0, 4'b0001, 4'b0000, 3'd1));
    rows.push_back(mk(0, 4'b0001, 0, 4'b0001, 4'b0001, 3'd1));
    for (int i = 0; i < 5; i++)
      rows.push_back(mk(0, 4'b0110, 1, 4'b1111, 4'b1111, 3'd4));
    rows.push_back(mk(0, 4'b0001, 0, 4'b0000, 4'b0000, 3'd0));
    rows.push_back(mk(0, 4'b0001, 0, 4'b0001, 4'b0000, 3'd1));
    rows.push_back(mk(0, 4'b0001, 0, 4'b0001, 4'b0001, 3'd1));
    foreach (rows[k]) begin
      rst = rows[k].r; req = rows[k].q; force_on = rows[k].f;
      sb.push_back('{rows[k].g, rows[k].y, rows[k].c});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (gate_en !== e.g || ready !== e.y || on_count !== e.c) begin
        errors++;
        $display("FAIL force row %0d: got %b %b %0d, want %b %b %0d",
                 k, gate_en, ready, on_count, e.g, e.y, e.c);
      end
    end
  endtask

  task automatic test_reset_midwake();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 4'b0000, 0, 4'b0000, 4'b0000, 3'd0));
    rows.push_back(mk(0, 4'b0001, 0, 4'b0001, 4'b0000, 3'd1));
    rows.push_back(mk(0, 4'b0001, 0, 4'b0001, 4'b0001, 3'd1));
    rows.push_back(mk(0, 4'b0100, 0, 4'b0101, 4'b0001, 3'd2));
    rows.push_back(mk(1, 4'b1100, 0, 4'b0000, 4'b0000, 3'd0));
    rows.push_back(mk(0, 4'b1100, 0, 4'b0100, 4'b0000, 3'd1));
    rows.push_back(mk(0, 4'b1100, 0, 4'b1100, 4'b0100, 3'd2));
    foreach (rows[k]) begin
      rst = rows[k].r; req = rows[k].q; force_on = rows[k].f;
      sb.push_back('{rows[k].g, rows[k].y, rows[k].c});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (gate_en !== e.g || ready !== e.y || on_count !== e.c) begin
        errors++;
        $display("FAIL reset_midwake row %0d: got %b %b %0d, want %b %b %0d",
                 k, gate_en, ready, on_count, e.g, e.y, e.c);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    req      = 4'b0000;
    force_on = 1'b0;
    @(posedge clk); #1;
    test_reset();
    mon_en = 1'b1;
    test_hysteresis();
    test_round_robin();
    test_preempt();
    test_boundary();
    test_force();
    test_reset_midwake();
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
